// File: rtl/mipi_pixel_tx_pkg.sv
// -----------------------------------------------------------------------------
// mipi_pixel_tx_pkg
// Shared definitions for the MIPI-bridge-style pixel stream transmitter:
//   - timing FSM state encoding
//   - test pattern selector codes
//   - Bayer RGGB colour constants
//   - 10-bit Fibonacci LFSR (x^10 + x^7 + 1) seed, taps and step function
//   - small constant helpers used to size counters
// -----------------------------------------------------------------------------
package mipi_pixel_tx_pkg;

  // Frame timing phases, in the order they occur within one frame.
  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_VSETUP = 3'd1,
    ST_LINE   = 3'd2,
    ST_HBLANK = 3'd3,
    ST_VBLANK = 3'd4
  } state_e;

  // Pattern selector codes.
  localparam logic [1:0] PAT_HRAMP = 2'd0;
  localparam logic [1:0] PAT_VRAMP = 2'd1;
  localparam logic [1:0] PAT_BAYER = 2'd2;
  localparam logic [1:0] PAT_LFSR  = 2'd3;

  // Bayer RGGB mosaic values (10-bit full scale; truncated or zero-extended
  // to the configured pixel width at the point of use).
  localparam logic [9:0] BAYER_R = 10'h3FF;
  localparam logic [9:0] BAYER_G = 10'h200;
  localparam logic [9:0] BAYER_B = 10'h000;

  // LFSR geometry. The register shifts towards the MSB; bit 9 is the oldest
  // bit (x^10 term) and bit 6 is the x^7 term.
  localparam int         LFSR_W      = 10;
  localparam logic [9:0] LFSR_SEED   = 10'h001;
  localparam int         LFSR_TAP_HI = 9;
  localparam int         LFSR_TAP_LO = 6;

  // One step of the Fibonacci LFSR.
  function automatic logic [LFSR_W-1:0] lfsr_next(input logic [LFSR_W-1:0] s);
    return {s[LFSR_W-2:0], s[LFSR_TAP_HI] ^ s[LFSR_TAP_LO]};
  endfunction

  // Counter width able to hold 0..n-1, never narrower than one bit.
  function automatic int cnt_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  // Largest of three values, used to size the shared phase counter.
  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    return m;
  endfunction

endpackage

// File: rtl/mipi_pixel_tx_pattern.sv
// -----------------------------------------------------------------------------
// mipi_pixel_tx_pattern
// Purely combinational test-pattern generator. Maps a pixel position (and the
// current LFSR state, which is owned by the timing FSM) to a pixel value.
//
// Ports:
//   sel_i    [1:0]        pattern code (PAT_HRAMP/VRAMP/BAYER/LFSR)
//   x_i      [XW-1:0]     column within the active line
//   y_i      [YW-1:0]     active line number within the frame
//   lfsr_i   [LFSR_W-1:0] LFSR state for this pixel
//   pixel_o  [DATA_W-1:0] pattern value (low DATA_W bits)
// -----------------------------------------------------------------------------
module mipi_pixel_tx_pattern
  import mipi_pixel_tx_pkg::*;
#(
  parameter int DATA_W = 10,
  parameter int XW     = 10,
  parameter int YW     = 9
) (
  input  logic [1:0]        sel_i,
  input  logic [XW-1:0]     x_i,
  input  logic [YW-1:0]     y_i,
  input  logic [LFSR_W-1:0] lfsr_i,
  output logic [DATA_W-1:0] pixel_o
);

  // Pattern select. Ramps wrap naturally through the width cast; the Bayer
  // colour is chosen by the parity of the row and column.
  always_comb begin
    pixel_o = '0;
    case (sel_i)
      PAT_HRAMP: pixel_o = DATA_W'(x_i);
      PAT_VRAMP: pixel_o = DATA_W'(y_i);
      PAT_BAYER: begin
        if (!y_i[0] && !x_i[0]) begin
          pixel_o = DATA_W'(BAYER_R);
        end else if (y_i[0] && x_i[0]) begin
          pixel_o = DATA_W'(BAYER_B);
        end else begin
          pixel_o = DATA_W'(BAYER_G);
        end
      end
      PAT_LFSR:  pixel_o = DATA_W'(lfsr_i);
      default:   pixel_o = '0;
    endcase
  end

endmodule

// File: rtl/mipi_pixel_tx.sv
// -----------------------------------------------------------------------------
// mipi_pixel_tx
// Parallel pixel-stream transmitter emulating a MIPI bridge output. Produces
// whole frames (VSETUP, H_ACTIVE x V_ACTIVE pixels with per-line blanking,
// VBLANK) carrying one of four built-in test patterns.
//
// Ports:
//   clk          pixel clock, rising edge
//   reset        asynchronous, active-high
//   enable       run frames; looked at only in IDLE and at the end of VBLANK
//   pattern_sel  pattern code, latched when a frame starts
//   pixel_d      pixel data, zero whenever pixel_hs is low
//   pixel_hs     high while pixel_d carries an active pixel
//   pixel_vs     high from frame setup through the last line's blanking
//   frame_done   one-cycle pulse on the first VBLANK cycle
//   frame_count  completed frames, wraps 0xFFFF -> 0
//
// Every output is a register loaded from the next-state values, so the
// outputs in a cycle always describe the state held in that same cycle.
// -----------------------------------------------------------------------------
module mipi_pixel_tx
  import mipi_pixel_tx_pkg::*;
#(
  parameter int H_ACTIVE = 640,
  parameter int H_BLANK  = 160,
  parameter int V_ACTIVE = 480,
  parameter int V_SETUP  = 4,
  parameter int V_BLANK  = 45,
  parameter int DATA_W   = 10
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              enable,
  input  logic [1:0]        pattern_sel,
  output logic [DATA_W-1:0] pixel_d,
  output logic              pixel_hs,
  output logic              pixel_vs,
  output logic              frame_done,
  output logic [15:0]       frame_count
);

  localparam int XW = cnt_width(H_ACTIVE);
  localparam int YW = cnt_width(V_ACTIVE);
  localparam int PW = cnt_width(max3(V_SETUP, H_BLANK, V_BLANK));

  localparam logic [XW-1:0] X_LAST      = XW'(H_ACTIVE - 1);
  localparam logic [YW-1:0] Y_LAST      = YW'(V_ACTIVE - 1);
  localparam logic [PW-1:0] SETUP_LAST  = PW'(V_SETUP - 1);
  localparam logic [PW-1:0] HBLANK_LAST = PW'(H_BLANK - 1);
  localparam logic [PW-1:0] VBLANK_LAST = PW'(V_BLANK - 1);

  state_e              state_q, state_d;
  logic [XW-1:0]       x_q, x_d;
  logic [YW-1:0]       y_q, y_d;
  logic [PW-1:0]       cnt_q, cnt_d;
  logic [LFSR_W-1:0]   lfsr_q, lfsr_d;
  logic [1:0]          sel_q, sel_d;
  logic [15:0]         frame_count_q, frame_count_d;
  logic                done_q, done_d;
  logic                hs_q, hs_d;
  logic                vs_q, vs_d;
  logic [DATA_W-1:0]   pix_q, pix_d;
  logic [DATA_W-1:0]   pat_pixel;

  // Next-state logic for the frame timing FSM. One shared phase counter
  // times VSETUP, HBLANK and VBLANK; x times the active part of a line.
  // Starting a frame (from IDLE or straight out of VBLANK) latches the
  // pattern code and reseeds the LFSR, so nothing changed mid-frame can
  // affect the pixels of the frame in progress.
  always_comb begin
    state_d       = state_q;
    x_d           = x_q;
    y_d           = y_q;
    cnt_d         = cnt_q;
    lfsr_d        = lfsr_q;
    sel_d         = sel_q;
    frame_count_d = frame_count_q;
    done_d        = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (enable) begin
          state_d = ST_VSETUP;
          cnt_d   = '0;
          sel_d   = pattern_sel;
          lfsr_d  = LFSR_SEED;
        end
      end

      ST_VSETUP: begin
        if (cnt_q == SETUP_LAST) begin
          state_d = ST_LINE;
          cnt_d   = '0;
          x_d     = '0;
          y_d     = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      ST_LINE: begin
        // The LFSR only moves on active pixels, so pixel k of the frame
        // carries the seed advanced k times, continuing across lines.
        lfsr_d = lfsr_next(lfsr_q);
        if (x_q == X_LAST) begin
          state_d = ST_HBLANK;
          cnt_d   = '0;
        end else begin
          x_d = x_q + 1'b1;
        end
      end

      ST_HBLANK: begin
        if (cnt_q == HBLANK_LAST) begin
          cnt_d = '0;
          if (y_q == Y_LAST) begin
            state_d       = ST_VBLANK;
            done_d        = 1'b1;
            frame_count_d = frame_count_q + 16'd1;
          end else begin
            state_d = ST_LINE;
            x_d     = '0;
            y_d     = y_q + 1'b1;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      ST_VBLANK: begin
        if (cnt_q == VBLANK_LAST) begin
          cnt_d = '0;
          if (enable) begin
            state_d = ST_VSETUP;
            sel_d   = pattern_sel;
            lfsr_d  = LFSR_SEED;
          end else begin
            state_d = ST_IDLE;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      default: begin
        state_d = ST_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // The pattern is evaluated on the next-cycle position so that the
  // registered pixel lines up with the registered hs.
  mipi_pixel_tx_pattern #(
    .DATA_W (DATA_W),
    .XW     (XW),
    .YW     (YW)
  ) u_pattern (
    .sel_i   (sel_d),
    .x_i     (x_d),
    .y_i     (y_d),
    .lfsr_i  (lfsr_d),
    .pixel_o (pat_pixel)
  );

  // Output decode for the coming cycle.
  assign vs_d  = (state_d == ST_VSETUP) || (state_d == ST_LINE) || (state_d == ST_HBLANK);
  assign hs_d  = (state_d == ST_LINE);
  assign pix_d = hs_d ? pat_pixel : '0;

  // State and output registers. Reset drops straight to an idle, all-zero
  // output with the LFSR holding its seed.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q       <= ST_IDLE;
      x_q           <= '0;
      y_q           <= '0;
      cnt_q         <= '0;
      lfsr_q        <= LFSR_SEED;
      sel_q         <= PAT_HRAMP;
      frame_count_q <= '0;
      done_q        <= 1'b0;
      hs_q          <= 1'b0;
      vs_q          <= 1'b0;
      pix_q         <= '0;
    end else begin
      state_q       <= state_d;
      x_q           <= x_d;
      y_q           <= y_d;
      cnt_q         <= cnt_d;
      lfsr_q        <= lfsr_d;
      sel_q         <= sel_d;
      frame_count_q <= frame_count_d;
      done_q        <= done_d;
      hs_q          <= hs_d;
      vs_q          <= vs_d;
      pix_q         <= pix_d;
    end
  end

  assign pixel_d     = pix_q;
  assign pixel_hs    = hs_q;
  assign pixel_vs    = vs_q;
  assign frame_done  = done_q;
  assign frame_count = frame_count_q;

endmodule

// File: tb/tb_mipi_pixel_tx.sv
// -----------------------------------------------------------------------------
// tb_mipi_pixel_tx
// Self-checking bench for mipi_pixel_tx on a small frame geometry. Expected
// outputs for every cycle of a frame come from a frame-relative timing model
// (plain arithmetic on the cycle index) and a bit-stream LFSR model.
// -----------------------------------------------------------------------------
module tb_mipi_pixel_tx;

  localparam int H_ACTIVE = 8;
  localparam int H_BLANK  = 2;
  localparam int V_ACTIVE = 3;
  localparam int V_SETUP  = 2;
  localparam int V_BLANK  = 3;
  localparam int DATA_W   = 10;
  localparam int LP       = H_ACTIVE + H_BLANK;
  localparam int VB_START = V_SETUP + V_ACTIVE * LP;
  localparam int FRAME    = VB_START + V_BLANK;
  localparam int NPIX     = H_ACTIVE * V_ACTIVE;

  logic              clk = 1'b0;
  logic              reset;
  logic              enable;
  logic [1:0]        pattern_sel;
  logic [DATA_W-1:0] pixel_d;
  logic              pixel_hs;
  logic              pixel_vs;
  logic              frame_done;
  logic [15:0]       frame_count;

  int          compareCount = 0;
  int          mismatchCount = 0;
  int          frameIdx = 0;
  logic [15:0] expCount;
  int          lfsrSeq[NPIX];

  mipi_pixel_tx #(
    .H_ACTIVE (H_ACTIVE),
    .H_BLANK  (H_BLANK),
    .V_ACTIVE (V_ACTIVE),
    .V_SETUP  (V_SETUP),
    .V_BLANK  (V_BLANK),
    .DATA_W   (DATA_W)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .enable      (enable),
    .pattern_sel (pattern_sel),
    .pixel_d     (pixel_d),
    .pixel_hs    (pixel_hs),
    .pixel_vs    (pixel_vs),
    .frame_done  (frame_done),
    .frame_count (frame_count)
  );

  // Free-running pixel clock, 10 time units per period.
  always #5 clk = ~clk;

  // Hard stop in case the sequence below ever stalls.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: observed no finish, required finish before time limit");
    $fatal(1, "[TB] watchdog expired");
  end

  // Single comparison point: counts it and reports a mismatch.
  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compareCount++;
    assert (obs === exp) else begin
      mismatchCount++;
      $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // LFSR reference as a bit stream: b[n+10] = b[n] ^ b[n+3] (x^10 + x^7 + 1).
  // The register window at step k holds b[k] (MSB) .. b[k+9] (LSB), and the
  // seed 0x001 is the window b[0..9] = 0,...,0,1.
  function automatic void buildLfsrModel();
    bit stream[NPIX + 10];
    for (int n = 0; n < NPIX + 10; n++) stream[n] = (n == 9);
    for (int n = 0; n + 10 < NPIX + 10; n++) stream[n + 10] = stream[n] ^ stream[n + 3];
    for (int k = 0; k < NPIX; k++) begin
      int v;
      v = 0;
      for (int j = 0; j < 10; j++) v = v + (int'(stream[k + 9 - j]) << j);
      lfsrSeq[k] = v;
    end
  endfunction

  // Pixel value for position (x, y) under pattern sel.
  function automatic int expPixel(input int sel, input int x, input int y);
    case (sel)
      0: return x % (1 << DATA_W);
      1: return y % (1 << DATA_W);
      2: begin
        if ((y % 2 == 0) && (x % 2 == 0)) return 'h3FF;
        if ((y % 2) != (x % 2))           return 'h200;
        return 0;
      end
      default: return lfsrSeq[y * H_ACTIVE + x];
    endcase
  endfunction

  // Checks a whole frame cycle by cycle. Called just after an edge with
  // enable already high, so the next edge starts VSETUP. Mid line 1 the
  // enable is dropped and pattern_sel scrambled; both are set to the
  // requested values for the next frame boundary on the last VBLANK cycle.
  task automatic applyStimulus(input int sel, input bit nextEnable, input logic [1:0] nextSel);
    int dropAt;
    dropAt = V_SETUP + LP + int'($urandom_range(0, LP - 1));
    frameIdx++;
    for (int t = 0; t < FRAME; t++) begin
      int expVs, expHs, expD, expDone;
      @(posedge clk);
      #1;
      expVs   = (t < VB_START) ? 1 : 0;
      expHs   = 0;
      expD    = 0;
      expDone = (t == VB_START) ? 1 : 0;
      if (t >= V_SETUP && t < VB_START) begin
        int r, x, y;
        r = t - V_SETUP;
        y = r / LP;
        x = r % LP;
        if (x < H_ACTIVE) begin
          expHs = 1;
          expD  = expPixel(sel, x, y);
        end
      end
      if (t == VB_START) expCount = expCount + 16'd1;
      checkOutput($sformatf("f%0d t%0d vs", frameIdx, t), 32'(pixel_vs), 32'(expVs));
      checkOutput($sformatf("f%0d t%0d hs", frameIdx, t), 32'(pixel_hs), 32'(expHs));
      checkOutput($sformatf("f%0d t%0d d", frameIdx, t), 32'(pixel_d), 32'(expD));
      checkOutput($sformatf("f%0d t%0d done", frameIdx, t), 32'(frame_done), 32'(expDone));
      checkOutput($sformatf("f%0d t%0d count", frameIdx, t), 32'(frame_count), 32'(expCount));
      if (t == dropAt) begin
        enable      = 1'b0;
        pattern_sel = 2'($urandom);
      end
      if (t == FRAME - 1) begin
        enable      = nextEnable;
        pattern_sel = nextSel;
      end
    end
  endtask

  // Confirms the block sits quietly in IDLE for n cycles.
  task automatic checkIdle(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
      checkOutput($sformatf("idle%0d vs", i), 32'(pixel_vs), 32'd0);
      checkOutput($sformatf("idle%0d hs", i), 32'(pixel_hs), 32'd0);
      checkOutput($sformatf("idle%0d d", i), 32'(pixel_d), 32'd0);
      checkOutput($sformatf("idle%0d done", i), 32'(frame_done), 32'd0);
      checkOutput($sformatf("idle%0d count", i), 32'(frame_count), 32'(expCount));
    end
  endtask

  initial begin
    logic [1:0] rsel, nsel;
    buildLfsrModel();

    // Power-on reset.
    reset       = 1'b1;
    enable      = 1'b0;
    pattern_sel = 2'd0;
    expCount    = 16'd0;
    repeat (3) @(posedge clk);
    #1;
    checkOutput("reset vs", 32'(pixel_vs), 32'd0);
    checkOutput("reset hs", 32'(pixel_hs), 32'd0);
    checkOutput("reset d", 32'(pixel_d), 32'd0);
    checkOutput("reset done", 32'(frame_done), 32'd0);
    checkOutput("reset count", 32'(frame_count), 32'd0);
    reset = 1'b0;
    checkIdle(2);

    // Single horizontal-ramp frame, then back to IDLE.
    $display("[TB] single frame, horizontal ramp");
    enable      = 1'b1;
    pattern_sel = 2'd0;
    applyStimulus(0, 1'b0, 2'd0);
    checkIdle(4);

    // Bayer frame followed back-to-back by two LFSR frames (the second
    // LFSR frame must restart from the seed).
    $display("[TB] back-to-back Bayer and LFSR frames");
    enable      = 1'b1;
    pattern_sel = 2'd2;
    applyStimulus(2, 1'b1, 2'd3);
    applyStimulus(3, 1'b1, 2'd3);
    applyStimulus(3, 1'b0, 2'd0);
    checkIdle(2);

    // Randomly chosen patterns, back to back.
    $display("[TB] random pattern frames");
    rsel        = 2'($urandom);
    enable      = 1'b1;
    pattern_sel = rsel;
    for (int f = 0; f < 4; f++) begin
      nsel = 2'($urandom);
      applyStimulus(int'(rsel), (f != 3), nsel);
      rsel = nsel;
    end
    checkIdle(2);

    // Asynchronous reset in the middle of line 0, released with enable high.
    $display("[TB] asynchronous reset mid line");
    enable      = 1'b1;
    pattern_sel = 2'd0;
    repeat (5) @(posedge clk);
    #1;
    checkOutput("preReset hs", 32'(pixel_hs), 32'd1);
    checkOutput("preReset d", 32'(pixel_d), 32'd2);
    #2;
    reset = 1'b1;
    #1;
    expCount = 16'd0;
    checkOutput("asyncReset vs", 32'(pixel_vs), 32'd0);
    checkOutput("asyncReset hs", 32'(pixel_hs), 32'd0);
    checkOutput("asyncReset d", 32'(pixel_d), 32'd0);
    checkOutput("asyncReset done", 32'(frame_done), 32'd0);
    checkOutput("asyncReset count", 32'(frame_count), 32'd0);
    #2;
    reset       = 1'b0;
    pattern_sel = 2'd1;
    applyStimulus(1, 1'b0, 2'd0);
    checkIdle(2);

    // frame_count wrap from 0xFFFF to 0.
    $display("[TB] frame counter wrap");
    force dut.frame_count_q = 16'hFFFF;
    #1;
    release dut.frame_count_q;
    expCount = 16'hFFFF;
    checkOutput("wrap preset", 32'(frame_count), 32'h0000FFFF);
    enable      = 1'b1;
    pattern_sel = 2'd0;
    applyStimulus(0, 1'b0, 2'd0);
    checkOutput("wrap result", 32'(frame_count), 32'h00000000);
    checkIdle(2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compareCount, mismatchCount);
    $finish;
  end

endmodule
